inst_loader: RTL and testbench
==============================

INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001: Parameter ADDR_WIDTH, default 15, sets the instruction-memory word-address width (32768 words).
REQ-002: Parameter BOOT_SKIP, default 0; when 1, the block leaves reset directly in RUN so a preloaded memory image executes without a UART load.
REQ-003: clk  input  1  single clock; all state updates on the rising edge.
REQ-004: rst  input  1  reset, synchronous, active-high.
REQ-005: rx_valid  input  1  one-cycle strobe: rx_data holds a received UART byte.
REQ-006: rx_data  input  8  received byte.
REQ-007: fetch_pc  input  32  core program counter (byte address).
REQ-008: fetch_inst  output  32  instruction returned to the core.
REQ-009: mem_addr  output  ADDR_WIDTH  word address to instruction memory.
REQ-010: mem_wdata  output  32  write data to instruction memory.
REQ-011: mem_we  output  1  write enable to instruction memory.
REQ-012: mem_rdata  input  32  asynchronous read data from instruction memory at mem_addr.
REQ-013: cpu_stall  output  1  holds the core (no PC advance, no retire) while 1.
REQ-014: load_done  output  1  level; program loaded, core running.
REQ-015: load_err  output  1  level; header word count exceeded memory capacity.

Function
REQ-016: FSM states SHALL be HDR, DATA, FLUSH, RUN, ERR.
REQ-017: Load format SHALL be a 4-byte little-endian word count N, then N words, each 4 bytes little-endian.
REQ-018: A 2-bit byte counter SHALL track the byte position within the current 32-bit field; it wraps 3->0 and resets to 0 on every state change.
REQ-019: HDR: on each rx_valid, the byte is shifted into count[8*k+7:8*k], k = byte counter.
REQ-020: HDR, 4th byte: N==0 -> RUN; N > 2^ADDR_WIDTH -> ERR; otherwise -> DATA with write address 0 and remaining = N.
REQ-021: DATA: bytes assemble into a shift register; on the 4th byte the assembled word is registered into mem_wdata, and mem_we is 1 for exactly the next cycle at mem_addr = current write address.
REQ-022: DATA: after each captured word, the write address increments by 1 and remaining decrements by 1; when the captured word is the last one (remaining==1), the next state is FLUSH instead of staying in DATA.
REQ-023: A byte arriving in the cycle in which mem_we is 1 SHALL be accepted as byte 0 of the next word; no byte is dropped at any rx_valid rate, including back-to-back.
REQ-024: FLUSH lasts one cycle, with mem_we=1 writing the last word; the next state is RUN.
REQ-025: In HDR, DATA, FLUSH and ERR: cpu_stall=1 and fetch_inst=32'h00000013 (NOP); mem_addr is the loader write address, or 0 in HDR and ERR.
REQ-026: In RUN: cpu_stall=0, mem_we=0, mem_addr=fetch_pc[ADDR_WIDTH+1:2] (combinational), fetch_inst=mem_rdata (combinational, zero latency), and fetch_pc[1:0] is ignored.
REQ-027: In RUN and ERR, rx_valid SHALL be ignored; both states are terminal until rst.
REQ-028: load_done = (state==RUN); load_err = (state==ERR).
REQ-029: mem_we SHALL never be 1 in HDR, RUN or ERR, and never for more than one cycle per captured word.
REQ-030: N == 2^ADDR_WIDTH is legal; the last write lands at address 2^ADDR_WIDTH-1, and the write address never wraps during a load.

Reset
REQ-031: While rst=1 at a clock edge: state=HDR (RUN if BOOT_SKIP=1), byte counter=0, count=0, write address=0, remaining=0, mem_wdata=0, mem_we=0.
REQ-032: Resulting output values after reset: cpu_stall=1, load_done=0, load_err=0, fetch_inst=NOP, mem_addr=0 (BOOT_SKIP=0). With BOOT_SKIP=1: cpu_stall=0 and load_done=1.
REQ-033: rst asserted mid-load SHALL abandon the load, with no further mem_we pulses; already-written words are not cleared.
REQ-034: rst takes priority over rx_valid in the same cycle.

Verification
REQ-035: Send bytes 02 00 00 00, 13 05 10 00, 6F 00 00 00 -> mem_we pulses at addr 0 with data 00100513 and at addr 1 with data 0000006F; the next cycle after FLUSH, load_done=1 and cpu_stall=0.
REQ-036: Header 00 00 00 00 -> RUN the cycle after the 4th byte, with no mem_we pulse.
REQ-037: Header 01 80 00 00 (N=32769, ADDR_WIDTH=15) -> load_err=1, cpu_stall=1, and later bytes produce no writes.
REQ-038: Back-to-back rx_valid for a 3-word load -> exactly 3 mem_we pulses at addresses 0, 1, 2 with the correct data.
REQ-039: In RUN with fetch_pc=0x00000008 -> mem_addr=2 and fetch_inst=mem_rdata in the same cycle; fetch_pc=0x0000000B -> mem_addr=2.
REQ-040: Assert rst after 6 data bytes of a 2-word load -> state HDR with mem_we=0; a fresh load then completes correctly. Separately, with BOOT_SKIP=1, the block runs immediately after reset.

Source files
------------

// File: rtl/inst_loader.sv
// UART program loader: receives a little-endian word count and program words,
// writes them into instruction memory, then hands the memory port to the core.
module inst_loader #(
    parameter int ADDR_WIDTH = 15,
    parameter bit BOOT_SKIP  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    input  logic [31:0]           fetch_pc,
    output logic [31:0]           fetch_inst,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  mem_we,
    input  logic [31:0]           mem_rdata,
    output logic                  cpu_stall,
    output logic                  load_done,
    output logic                  load_err
);

    typedef enum logic [2:0] {HDR, DATA, FLUSH, RUN, ERR} state_t;

    localparam logic [32:0] CAPACITY = 33'd1 << ADDR_WIDTH;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [ADDR_WIDTH:0] REM_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [1:0]            bcnt_q, bcnt_d;
    logic [31:0]           count_q, count_d;
    logic [31:0]           shift_q, shift_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [ADDR_WIDTH:0]   waddr_q, waddr_d;
    logic [ADDR_WIDTH:0]   remain_q, remain_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic                  we_q, we_d;

    logic [31:0] hdr_n;
    logic [31:0] word_in;
    logic        unused_ok;

    // The final header byte completes N combinationally so the decision is made on that byte.
    assign hdr_n   = {rx_data, count_q[23:0]};
    assign word_in = {rx_data, shift_q[31:8]};

    always_comb begin
        state_d   = state_q;
        bcnt_d    = bcnt_q;
        count_d   = count_q;
        shift_d   = shift_q;
        wdata_d   = wdata_q;
        waddr_d   = waddr_q;
        remain_d  = remain_q;
        wr_addr_d = wr_addr_q;
        we_d      = 1'b0;
        case (state_q)
            HDR: begin
                if (rx_valid) begin
                    count_d[{bcnt_q, 3'b000} +: 8] = rx_data;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        bcnt_d = '0;
                        if (hdr_n == '0) begin
                            state_d = RUN;
                        end else if ({1'b0, hdr_n} > CAPACITY) begin
                            state_d = ERR;
                        end else begin
                            state_d  = DATA;
                            waddr_d  = '0;
                            remain_d = hdr_n[ADDR_WIDTH:0];
                        end
                    end
                end
            end
            DATA: begin
                if (rx_valid) begin
                    shift_d = word_in;
                    bcnt_d  = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        bcnt_d    = '0;
                        wdata_d   = word_in;
                        we_d      = 1'b1;
                        wr_addr_d = waddr_q[ADDR_WIDTH-1:0];
                        waddr_d   = waddr_q + 1'b1;
                        remain_d  = remain_q - 1'b1;
                        if (remain_q == REM_ONE) begin
                            state_d = FLUSH;
                        end
                    end
                end
            end
            FLUSH:   state_d = RUN;
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= BOOT_SKIP ? RUN : HDR;
            bcnt_q    <= '0;
            count_q   <= '0;
            shift_q   <= '0;
            wdata_q   <= '0;
            waddr_q   <= '0;
            remain_q  <= '0;
            wr_addr_q <= '0;
            we_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bcnt_q    <= bcnt_d;
            count_q   <= count_d;
            shift_q   <= shift_d;
            wdata_q   <= wdata_d;
            waddr_q   <= waddr_d;
            remain_q  <= remain_d;
            wr_addr_q <= wr_addr_d;
            we_q      <= we_d;
        end
    end

    // The write pulse uses the address latched at capture, since waddr_q has already advanced.
    always_comb begin
        case (state_q)
            RUN:         mem_addr = fetch_pc[ADDR_WIDTH+1:2];
            DATA, FLUSH: mem_addr = wr_addr_q;
            default:     mem_addr = '0;
        endcase
    end

    assign fetch_inst = (state_q == RUN) ? mem_rdata : NOP;
    assign mem_wdata  = wdata_q;
    assign mem_we     = we_q;
    assign cpu_stall  = (state_q != RUN);
    assign load_done  = (state_q == RUN);
    assign load_err   = (state_q == ERR);

    assign unused_ok = ^{fetch_pc[31:ADDR_WIDTH+2], fetch_pc[1:0], count_q[31:24], shift_q[7:0]};

endmodule

// File: tb/tb_inst_loader.sv
// Randomized scoreboard bench for inst_loader: a reference model derives the
// expected memory writes from the load stream and a monitor checks each write pulse.
module tb_inst_loader;

    localparam int          AW  = 15;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef logic [7:0]  bq_t[$];
    typedef logic [31:0] wq_t[$];
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic [31:0]   fetch_pc;
    logic [31:0]   fetch_inst, fetch_inst_b;
    logic [AW-1:0] mem_addr, mem_addr_b;
    logic [31:0]   mem_wdata, mem_wdata_b;
    logic          mem_we, mem_we_b;
    logic [31:0]   mem_rdata, mem_rdata_b;
    logic          cpu_stall, cpu_stall_b;
    logic          load_done, load_done_b;
    logic          load_err, load_err_b;

    logic [31:0] mem     [0:(1<<AW)-1];
    logic [31:0] ref_mem [0:(1<<AW)-1];
    wr_t         expq[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    inst_loader #(.ADDR_WIDTH(AW), .BOOT_SKIP(1'b0)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .fetch_pc(fetch_pc), .fetch_inst(fetch_inst), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .cpu_stall(cpu_stall), .load_done(load_done), .load_err(load_err)
    );

    inst_loader #(.ADDR_WIDTH(AW), .BOOT_SKIP(1'b1)) dut_b (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .fetch_pc(fetch_pc), .fetch_inst(fetch_inst_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_we(mem_we_b), .mem_rdata(mem_rdata_b),
        .cpu_stall(cpu_stall_b), .load_done(load_done_b), .load_err(load_err_b)
    );

    assign mem_rdata   = mem[mem_addr];
    assign mem_rdata_b = {{(32-AW){1'b0}}, mem_addr_b};

    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write pulse must match the next expected write.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %h data %h, want no write", mem_addr, mem_wdata);
            end else begin
                wr_t e;
                e = expq.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(e.addr));
                chk("wr_data", mem_wdata, e.data);
            end
        end
        if (mem_we_b === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL boot_skip_write: addr %h, want no write", mem_addr_b);
        end
    end

    function automatic wq_t rand_words(input int n);
        wq_t w;
        for (int i = 0; i < n; i++) w.push_back($urandom);
        return w;
    endfunction

    // Reference model: serialise a load and record the writes it must cause.
    task automatic build(input logic [31:0] n, input wq_t words, input bit expect_wr, output bq_t bq);
        bq = {};
        for (int i = 0; i < 4; i++) bq.push_back(n[8*i +: 8]);
        foreach (words[i]) begin
            for (int b = 0; b < 4; b++) bq.push_back(words[i][8*b +: 8]);
            if (expect_wr && n > 0 && n <= (1 << AW)) begin
                expq.push_back(wr_t'{AW'(i), words[i]});
                ref_mem[i] = words[i];
            end
        end
    endtask

    // Starts and ends at posedge+1; ends one cycle after the last byte's edge.
    task automatic send(input bq_t bq, input int maxgap);
        foreach (bq[i]) begin
            if (i > 0) repeat ($urandom_range(maxgap, 0)) begin @(posedge clk); #1; end
            rx_valid = 1'b1;
            rx_data  = bq[i];
            @(posedge clk); #1;
            rx_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
    endtask

    task automatic finish_data_load();
        @(negedge clk);
        chk("flush_we", mem_we, 1);
        chk("flush_stall", cpu_stall, 1);
        chk("flush_done", load_done, 0);
        @(negedge clk);
        chk("run_done", load_done, 1);
        chk("run_stall", cpu_stall, 0);
        chk("run_we", mem_we, 0);
        chk("sb_drained", expq.size(), 0);
    endtask

    task automatic fetch_checks(input int n, input int reps);
        for (int r = 0; r < reps; r++) begin
            int idx;
            idx = $urandom_range(n - 1, 0);
            @(posedge clk); #1;
            fetch_pc = 32'(idx) * 4 + 32'($urandom_range(3, 0));
            @(negedge clk);
            chk("fetch_addr", 32'(mem_addr), 32'(idx));
            chk("fetch_inst", fetch_inst, ref_mem[idx]);
            chk("boot_fetch", fetch_inst_b, 32'(idx));
        end
    endtask

    initial begin
        bq_t bq, part;
        int  n;
        rst = 1'b1;
        rx_valid = 1'b0;
        rx_data = '0;
        fetch_pc = '0;

        do_reset();
        @(negedge clk);
        chk("rst_stall", cpu_stall, 1);
        chk("rst_done", load_done, 0);
        chk("rst_err", load_err, 0);
        chk("rst_inst", fetch_inst, NOP);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_we", mem_we, 0);
        chk("boot_done", load_done_b, 1);
        chk("boot_stall", cpu_stall_b, 0);

        // Two-word program with random byte gaps.
        @(posedge clk); #1;
        build(32'd2, '{32'h0010_0513, 32'h0000_006F}, 1'b1, bq);
        send(bq, 3);
        finish_data_load();
        @(posedge clk); #1; fetch_pc = 32'h0000_0008;
        @(negedge clk);
        chk("pc8_addr", 32'(mem_addr), 2);
        chk("pc8_inst", fetch_inst, mem[2]);
        @(posedge clk); #1; fetch_pc = 32'h0000_000B;
        @(negedge clk);
        chk("pcB_addr", 32'(mem_addr), 2);
        fetch_checks(2, 4);

        // Zero-length header goes straight to RUN with no writes.
        do_reset();
        build(32'd0, '{}, 1'b1, bq);
        send(bq, 2);
        @(negedge clk);
        chk("n0_done", load_done, 1);
        chk("n0_stall", cpu_stall, 0);
        chk("n0_drained", expq.size(), 0);

        // Oversized header: ERR is terminal and later bytes write nothing.
        do_reset();
        build(32'd32769, '{}, 1'b1, bq);
        send(bq, 2);
        @(negedge clk);
        chk("err_flag", load_err, 1);
        chk("err_stall", cpu_stall, 1);
        chk("err_inst", fetch_inst, NOP);
        @(posedge clk); #1;
        bq = {};
        for (int i = 0; i < 16; i++) bq.push_back(8'($urandom));
        send(bq, 2);
        @(negedge clk);
        chk("err_hold", load_err, 1);
        chk("err_done", load_done, 0);

        // Full-capacity count is legal; two words of it are checked.
        do_reset();
        build(32'd32768, rand_words(2), 1'b1, bq);
        send(bq, 1);
        repeat (2) @(negedge clk);
        chk("cap_err", load_err, 0);
        chk("cap_stall", cpu_stall, 1);
        chk("cap_drained", expq.size(), 0);

        // Back-to-back three-word load.
        do_reset();
        build(32'd3, rand_words(3), 1'b1, bq);
        send(bq, 0);
        finish_data_load();
        fetch_checks(3, 3);

        // Reset after six data bytes: only word 0 is written.
        do_reset();
        build(32'd2, rand_words(2), 1'b0, bq);
        expq.push_back(wr_t'{AW'(0), {bq[7], bq[6], bq[5], bq[4]}});
        part = bq[0:9];
        send(part, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_we", mem_we, 0);
        chk("mid_rst_stall", cpu_stall, 1);
        chk("mid_rst_addr", 32'(mem_addr), 0);
        chk("mid_rst_drained", expq.size(), 0);
        @(posedge clk); #1;
        build(32'd2, rand_words(2), 1'b1, bq);
        send(bq, 2);
        finish_data_load();
        fetch_checks(2, 2);

        // Random loads.
        for (int t = 0; t < 6; t++) begin
            do_reset();
            n = $urandom_range(24, 1);
            build(32'(n), rand_words(n), 1'b1, bq);
            send(bq, $urandom_range(3, 0));
            finish_data_load();
            fetch_checks(n, 4);
        end

        chk("boot_hold", load_done_b, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
